// File: rtl/dram_access_arbiter_if.sv
// Bundle of the core-array, com-port and data-memory signals around the
// DRAM access arbiter. The arbiter uses the slave modport; requesters and memory use master.
interface dram_access_arbiter_if #(
  parameter int NUM_C = 4,
  parameter int AW    = 16,
  parameter int DW    = 16
);
  logic [1:0]          status;

  logic [NUM_C-1:0]    core_req;
  logic [NUM_C-1:0]    core_we;
  logic [NUM_C*AW-1:0] core_addr;
  logic [NUM_C*DW-1:0] core_wdata;
  logic [NUM_C-1:0]    core_ack;
  logic [DW-1:0]       core_rdata;

  logic                com_req;
  logic                com_we;
  logic [AW-1:0]       com_addr;
  logic [DW-1:0]       com_wdata;
  logic                com_ack;
  logic [DW-1:0]       com_rdata;

  logic                mem_en;
  logic                mem_we;
  logic [AW-1:0]       mem_addr;
  logic [DW-1:0]       mem_wdata;
  logic [DW-1:0]       mem_rdata;

  modport slave (
    input  status, core_req, core_we, core_addr, core_wdata,
    input  com_req, com_we, com_addr, com_wdata, mem_rdata,
    output core_ack, core_rdata, com_ack, com_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output status, core_req, core_we, core_addr, core_wdata,
    output com_req, com_we, com_addr, com_wdata, mem_rdata,
    input  core_ack, core_rdata, com_ack, com_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dram_access_arbiter.sv
// Single-port data-memory sequencer: round-robin among cores while running,
// exclusive com-port access otherwise. One access in flight, IDLE->ISSUE->RESP.
module dram_access_arbiter #(
  parameter int NUM_C = 4,
  parameter int AW    = 16,
  parameter int DW    = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  dram_access_arbiter_if.slave bus
);
  localparam int         IDW        = (NUM_C > 1) ? $clog2(NUM_C) : 1;
  localparam logic [1:0] STATUS_RUN = 2'b01;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]   win_id_q, win_id_d;
  logic             win_com_q, win_com_d;
  logic             mem_en_q, mem_en_d;
  logic             mem_we_q, mem_we_d;
  logic [AW-1:0]    mem_addr_q, mem_addr_d;
  logic [DW-1:0]    mem_wdata_q, mem_wdata_d;
  logic [NUM_C-1:0] core_ack_q, core_ack_d;
  logic             com_ack_q, com_ack_d;
  logic [DW-1:0]    core_rdata_q, core_rdata_d;
  logic [DW-1:0]    com_rdata_q, com_rdata_d;

  logic             is_run;
  logic [NUM_C-1:0] core_elig;
  logic             com_elig;
  logic             core_found;
  logic [IDW-1:0]   core_pick;
  int               idx;

  always_comb begin
    is_run     = (bus.status == STATUS_RUN);
    // The requester being acked this cycle still holds req high; keep it out.
    core_elig  = is_run ? (bus.core_req & ~core_ack_q) : '0;
    com_elig   = !is_run && bus.com_req && !com_ack_q;
    core_found = 1'b0;
    core_pick  = '0;
    idx        = 0;
    for (int k = 0; k < NUM_C; k++) begin
      idx = (int'(rr_ptr_q) + k) % NUM_C;
      if (!core_found && core_elig[idx]) begin
        core_found = 1'b1;
        core_pick  = IDW'(idx);
      end
    end
  end

  always_comb begin
    // NOTE: every _d starts from a default, so no branch can leave it unassigned and infer a latch.
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    win_id_d     = win_id_q;
    win_com_d    = win_com_q;
    mem_en_d     = 1'b0;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    core_ack_d   = '0;
    com_ack_d    = 1'b0;
    core_rdata_d = core_rdata_q;
    com_rdata_d  = com_rdata_q;

    unique case (state_q)
      S_IDLE: begin
        if (core_found) begin
          win_com_d   = 1'b0;
          win_id_d    = core_pick;
          rr_ptr_d    = (int'(core_pick) == NUM_C - 1) ? '0 : core_pick + 1'b1;
          mem_en_d    = 1'b1;
          mem_we_d    = bus.core_we[core_pick];
          mem_addr_d  = bus.core_addr[core_pick*AW +: AW];
          mem_wdata_d = bus.core_wdata[core_pick*DW +: DW];
          state_d     = S_ISSUE;
        end else if (com_elig) begin
          win_com_d   = 1'b1;
          mem_en_d    = 1'b1;
          mem_we_d    = bus.com_we;
          mem_addr_d  = bus.com_addr;
          mem_wdata_d = bus.com_wdata;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        mem_we_d = 1'b0;
        state_d  = S_RESP;
      end
      S_RESP: begin
        // Writes also capture mem_rdata; the value is whatever memory last returned.
        if (win_com_q) begin
          com_ack_d   = 1'b1;
          com_rdata_d = bus.mem_rdata;
        end else begin
          core_ack_d   = NUM_C'(1) << win_id_q;
          core_rdata_d = bus.mem_rdata;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      rr_ptr_q     <= '0;
      win_id_q     <= '0;
      win_com_q    <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      core_ack_q   <= '0;
      com_ack_q    <= 1'b0;
      core_rdata_q <= '0;
      com_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      win_id_q     <= win_id_d;
      win_com_q    <= win_com_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      core_ack_q   <= core_ack_d;
      com_ack_q    <= com_ack_d;
      core_rdata_q <= core_rdata_d;
      com_rdata_q  <= com_rdata_d;
    end
  end

  assign bus.mem_en     = mem_en_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.core_ack   = core_ack_q;
  assign bus.core_rdata = core_rdata_q;
  assign bus.com_ack    = com_ack_q;
  assign bus.com_rdata  = com_rdata_q;
endmodule

// File: tb/tb_dram_access_arbiter.sv
// Bench for dram_access_arbiter: fixed vector table, hand-written multi-cycle
// sequences, then random traffic against a transaction-level reference model.
module tb_dram_access_arbiter;
  localparam int NUM_C = 4;
  localparam int AW    = 16;
  localparam int DW    = 16;
  localparam logic [1:0] ST_LOAD   = 2'b00;
  localparam logic [1:0] ST_RUN    = 2'b01;
  localparam logic [1:0] ST_UNLOAD = 2'b10;
  localparam logic [1:0] ST_IDLE   = 2'b11;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dram_access_arbiter_if #(.NUM_C(NUM_C), .AW(AW), .DW(DW)) bus ();

  dram_access_arbiter #(.NUM_C(NUM_C), .AW(AW), .DW(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Synchronous memory: read-first, data one cycle after the strobe.
  logic [DW-1:0] mem [0:65535];
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      bus.mem_rdata <= mem[bus.mem_addr];
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.status     = ST_IDLE;
    bus.core_req   = '0;
    bus.core_we    = '0;
    bus.core_addr  = '0;
    bus.core_wdata = '0;
    bus.com_req    = 1'b0;
    bus.com_we     = 1'b0;
    bus.com_addr   = '0;
    bus.com_wdata  = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic set_core(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.core_we[i]             = we;
    bus.core_addr[i*AW +: AW]  = a;
    bus.core_wdata[i*DW +: DW] = d;
  endtask

  logic [AW-1:0] core_a [NUM_C];

  task automatic load_fixed_fields();
    for (int i = 0; i < NUM_C; i++) set_core(i, 1'b0, core_a[i], '0);
    bus.com_we    = 1'b0;
    bus.com_addr  = 16'h0020;
    bus.com_wdata = '0;
  endtask

  typedef struct {
    logic [1:0]  status;
    logic [3:0]  core_req;
    logic        com_req;
    logic [3:0]  exp_ack;
    logic        exp_com;
    logic [15:0] exp_addr;
    logic [15:0] exp_rdata;
  } vec_t;
  vec_t vecs [8];

  // Reference model state: an access occupies the three cycles after its grant edge.
  int            m_age;
  int            m_win;
  int            m_rr;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata;
  logic [DW-1:0] ref_mem [0:63];

  task automatic model_step();
    int cand;
    int masked;
    int c;
    if (m_age == 0 || m_age == 3) begin
      masked = (m_age == 3) ? m_win : -1;
      cand   = -1;
      if (bus.status == ST_RUN) begin
        for (int k = 0; k < NUM_C; k++) begin
          c = (m_rr + k) % NUM_C;
          if (cand < 0 && bus.core_req[c] && c != masked) cand = c;
        end
      end else if (bus.com_req && masked != NUM_C) begin
        cand = NUM_C;
      end
      if (cand >= 0) begin
        m_win = cand;
        if (cand < NUM_C) begin
          m_we    = bus.core_we[cand];
          m_addr  = bus.core_addr[cand*AW +: AW];
          m_wdata = bus.core_wdata[cand*DW +: DW];
          m_rr    = (cand + 1) % NUM_C;
        end else begin
          m_we    = bus.com_we;
          m_addr  = bus.com_addr;
          m_wdata = bus.com_wdata;
        end
        if (m_we) ref_mem[m_addr[5:0]] = m_wdata;
        else      m_rdata = ref_mem[m_addr[5:0]];
        m_age = 1;
      end else begin
        m_age = 0;
      end
    end else begin
      m_age++;
    end
  endtask

  task automatic model_check();
    logic [31:0] exp_core;
    exp_core = (m_age == 3 && m_win < NUM_C) ? (32'd1 << m_win) : 32'd0;
    check("rnd mem_en", 32'(bus.mem_en), 32'(m_age == 1));
    check("rnd core_ack", 32'(bus.core_ack), exp_core);
    check("rnd com_ack", 32'(bus.com_ack), 32'(m_age == 3 && m_win == NUM_C));
    if (m_age == 1) begin
      check("rnd mem_we", 32'(bus.mem_we), 32'(m_we));
      check("rnd mem_addr", 32'(bus.mem_addr), 32'(m_addr));
      if (m_we) check("rnd mem_wdata", 32'(bus.mem_wdata), 32'(m_wdata));
    end
    if (m_age == 3 && !m_we) begin
      if (m_win < NUM_C) check("rnd core_rdata", 32'(bus.core_rdata), 32'(m_rdata));
      else               check("rnd com_rdata", 32'(bus.com_rdata), 32'(m_rdata));
    end
  endtask

  task automatic new_core_fields(input int i);
    set_core(i, 1'($urandom_range(1)), 16'h0100 + 16'($urandom_range(63)), 16'($urandom));
  endtask

  task automatic new_com_fields();
    bus.com_we    = 1'($urandom_range(1));
    bus.com_addr  = 16'h0100 + 16'($urandom_range(63));
    bus.com_wdata = 16'($urandom);
  endtask

  task automatic drive_next();
    for (int i = 0; i < NUM_C; i++) begin
      if (bus.core_ack[i]) begin
        if ($urandom_range(1) == 0) bus.core_req[i] = 1'b0;
        else new_core_fields(i);
      end else if (!bus.core_req[i] && $urandom_range(3) == 0) begin
        bus.core_req[i] = 1'b1;
        new_core_fields(i);
      end
    end
    if (bus.com_ack) begin
      if ($urandom_range(1) == 0) bus.com_req = 1'b0;
      else new_com_fields();
    end else if (!bus.com_req && $urandom_range(3) == 0) begin
      bus.com_req = 1'b1;
      new_com_fields();
    end
    if ($urandom_range(15) == 0)
      bus.status = ($urandom_range(1) == 1) ? ST_RUN : 2'($urandom_range(3));
  endtask

  initial begin
    logic [DW-1:0] d;
    logic [3:0]    exp_ack;

    core_a[0] = 16'h0030;
    core_a[1] = 16'h0031;
    core_a[2] = 16'h0010;
    core_a[3] = 16'h0033;
    for (int a = 0; a < 65536; a++) mem[a] = 16'(a) ^ 16'h5A5A;
    mem[16'h0010] = 16'hBEEF;

    vecs[0] = '{ST_RUN,    4'b0100, 1'b0, 4'b0100, 1'b0, 16'h0010, 16'hBEEF};
    vecs[1] = '{ST_RUN,    4'b1010, 1'b0, 4'b0010, 1'b0, 16'h0031, 16'h5A6B};
    vecs[2] = '{ST_LOAD,   4'b1111, 1'b1, 4'b0000, 1'b1, 16'h0020, 16'h5A7A};
    vecs[3] = '{ST_UNLOAD, 4'b0001, 1'b0, 4'b0000, 1'b0, 16'h0000, 16'h0000};
    vecs[4] = '{ST_IDLE,   4'b0000, 1'b1, 4'b0000, 1'b1, 16'h0020, 16'h5A7A};
    vecs[5] = '{ST_RUN,    4'b0000, 1'b1, 4'b0000, 1'b0, 16'h0000, 16'h0000};
    vecs[6] = '{ST_RUN,    4'b1001, 1'b1, 4'b0001, 1'b0, 16'h0030, 16'h5A6A};
    vecs[7] = '{ST_RUN,    4'b1000, 1'b0, 4'b1000, 1'b0, 16'h0033, 16'h5A69};

    // Reset state
    clear_inputs();
    tick();
    check("rst mem_en", 32'(bus.mem_en), 32'd0);
    check("rst mem_we", 32'(bus.mem_we), 32'd0);
    check("rst mem_addr", 32'(bus.mem_addr), 32'd0);
    check("rst mem_wdata", 32'(bus.mem_wdata), 32'd0);
    check("rst core_ack", 32'(bus.core_ack), 32'd0);
    check("rst com_ack", 32'(bus.com_ack), 32'd0);
    check("rst core_rdata", 32'(bus.core_rdata), 32'd0);
    check("rst com_rdata", 32'(bus.com_rdata), 32'd0);

    // Single-access vector table, each from a fresh reset
    for (int v = 0; v < 8; v++) begin
      do_reset();
      load_fixed_fields();
      bus.status   = vecs[v].status;
      bus.core_req = vecs[v].core_req;
      bus.com_req  = vecs[v].com_req;
      tick();
      check($sformatf("vec%0d mem_en", v), 32'(bus.mem_en),
            32'(vecs[v].exp_ack != 4'b0 || vecs[v].exp_com));
      if (vecs[v].exp_ack != 4'b0 || vecs[v].exp_com)
        check($sformatf("vec%0d mem_addr", v), 32'(bus.mem_addr), 32'(vecs[v].exp_addr));
      tick();
      tick();
      check($sformatf("vec%0d core_ack", v), 32'(bus.core_ack), 32'(vecs[v].exp_ack));
      check($sformatf("vec%0d com_ack", v), 32'(bus.com_ack), 32'(vecs[v].exp_com));
      if (vecs[v].exp_ack != 4'b0)
        check($sformatf("vec%0d core_rdata", v), 32'(bus.core_rdata), 32'(vecs[v].exp_rdata));
      if (vecs[v].exp_com)
        check($sformatf("vec%0d com_rdata", v), 32'(bus.com_rdata), 32'(vecs[v].exp_rdata));
    end

    // All four cores held: grant order 0,1,2,3,0 with acks 3 cycles apart
    do_reset();
    load_fixed_fields();
    bus.status   = ST_RUN;
    bus.core_req = 4'b1111;
    for (int c = 1; c <= 15; c++) begin
      tick();
      exp_ack = (c % 3 == 0) ? (4'b0001 << (((c / 3) - 1) % 4)) : 4'b0000;
      check($sformatf("rr c%0d core_ack", c), 32'(bus.core_ack), 32'(exp_ack));
    end
    bus.core_req = '0;
    tick();

    // Com write during load; core1 waits until run
    do_reset();
    load_fixed_fields();
    bus.status    = ST_LOAD;
    bus.com_we    = 1'b1;
    bus.com_addr  = 16'h0005;
    bus.com_wdata = 16'h1234;
    bus.com_req   = 1'b1;
    bus.core_req  = 4'b0010;
    tick();
    check("load mem_en", 32'(bus.mem_en), 32'd1);
    check("load mem_we", 32'(bus.mem_we), 32'd1);
    check("load mem_addr", 32'(bus.mem_addr), 32'h0005);
    check("load mem_wdata", 32'(bus.mem_wdata), 32'h1234);
    tick();
    check("load mem_we cleared", 32'(bus.mem_we), 32'd0);
    check("load addr held", 32'(bus.mem_addr), 32'h0005);
    tick();
    check("load com_ack", 32'(bus.com_ack), 32'd1);
    check("load core_ack", 32'(bus.core_ack), 32'd0);
    bus.com_req = 1'b0;
    bus.com_we  = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      check("load core1 pending", 32'(bus.core_ack), 32'd0);
    end
    check("load mem written", 32'(mem[16'h0005]), 32'h1234);
    bus.status = ST_RUN;
    tick();
    tick();
    tick();
    check("load core1 run ack", 32'(bus.core_ack), 32'b0010);
    check("load core1 rdata", 32'(bus.core_rdata), 32'h5A6B);
    bus.core_req = '0;
    tick();

    // Status change mid-access does not abort; com wins next, core0 stays pending
    do_reset();
    load_fixed_fields();
    bus.status   = ST_RUN;
    bus.core_req = 4'b1000;
    tick();
    check("swap mem_addr", 32'(bus.mem_addr), 32'h0033);
    bus.status   = ST_UNLOAD;
    bus.core_req = 4'b1001;
    bus.com_req  = 1'b1;
    tick();
    tick();
    check("swap core3 ack", 32'(bus.core_ack), 32'b1000);
    check("swap core3 rdata", 32'(bus.core_rdata), 32'h5A69);
    bus.core_req = 4'b0001;
    tick();
    tick();
    tick();
    check("swap com_ack", 32'(bus.com_ack), 32'd1);
    check("swap com_rdata", 32'(bus.com_rdata), 32'h5A7A);
    bus.com_req = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      check("swap core0 pending", 32'(bus.core_ack), 32'd0);
    end
    bus.core_req = '0;

    // Reset during ISSUE abandons the access and clears the pointer
    do_reset();
    load_fixed_fields();
    bus.status   = ST_RUN;
    bus.core_req = 4'b0001;
    tick();
    tick();
    tick();
    check("rst5 core0 ack", 32'(bus.core_ack), 32'b0001);
    bus.core_req = '0;
    bus.status   = ST_LOAD;
    bus.com_req  = 1'b1;
    tick();
    check("rst5 issue mem_en", 32'(bus.mem_en), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst5 mem_en", 32'(bus.mem_en), 32'd0);
    tick();
    tick();
    check("rst5 com_ack", 32'(bus.com_ack), 32'd0);
    check("rst5 core_ack", 32'(bus.core_ack), 32'd0);
    bus.com_req  = 1'b0;
    bus.status   = ST_RUN;
    bus.core_req = 4'b0011;
    rst_n        = 1'b1;
    tick();
    check("rst5 no stale ack", 32'(bus.com_ack), 32'd0);
    tick();
    tick();
    check("rst5 core0 first", 32'(bus.core_ack), 32'b0001);
    tick();
    tick();
    tick();
    check("rst5 core1 second", 32'(bus.core_ack), 32'b0010);
    bus.core_req = '0;
    tick();

    // Core1 held through its ack: next grant one cycle later
    do_reset();
    load_fixed_fields();
    bus.status   = ST_RUN;
    bus.core_req = 4'b0010;
    for (int c = 1; c <= 8; c++) begin
      tick();
      check($sformatf("hold c%0d mem_en", c), 32'(bus.mem_en), 32'(c == 1 || c == 5));
      check($sformatf("hold c%0d core_ack", c), 32'(bus.core_ack),
            (c == 3 || c == 7) ? 32'b0010 : 32'd0);
    end
    bus.core_req = '0;
    tick();

    // Random traffic against the reference model
    do_reset();
    for (int a = 0; a < 64; a++) begin
      d = 16'($urandom);
      mem[16'h0100 + 16'(a)] = d;
      ref_mem[a] = d;
    end
    m_age      = 0;
    m_win      = -1;
    m_rr       = 0;
    m_we       = 1'b0;
    m_addr     = '0;
    m_wdata    = '0;
    m_rdata    = '0;
    bus.status = ST_RUN;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      model_step();
      tick();
      model_check();
      drive_next();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
